// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-unit bundle: ID/EX/MEM hazard inputs in, pipeline
// register enable, bubble and MULT/DIV sequencing controls out.
interface pipeline_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rs_addr_ID;
  logic [REG_ADDR_W-1:0] rt_addr_ID;
  logic                  use_rs_ID;
  logic                  use_rt_ID;
  logic                  store_ID;
  logic [REG_ADDR_W-1:0] target_EX;
  logic                  MemRead_EX;
  logic                  muldiv_EX;
  logic                  is_div_EX;
  logic                  flush_MEM;

  logic stall_PC;
  logic stall_IF_ID;
  logic stall_ID_EX;
  logic bubble_EX;
  logic bubble_MEM;
  logic flush_all;
  logic muldiv_start;
  logic muldiv_done;
  logic busy;

  modport master (
    output rs_addr_ID, rt_addr_ID,
    output use_rs_ID, use_rt_ID, store_ID,
    output target_EX, MemRead_EX,
    output muldiv_EX, is_div_EX, flush_MEM,
    input  stall_PC, stall_IF_ID, stall_ID_EX,
    input  bubble_EX, bubble_MEM, flush_all,
    input  muldiv_start, muldiv_done, busy
  );

  modport slave (
    input  rs_addr_ID, rt_addr_ID,
    input  use_rs_ID, use_rt_ID, store_ID,
    input  target_EX, MemRead_EX,
    input  muldiv_EX, is_div_EX, flush_MEM,
    output stall_PC, stall_IF_ID, stall_ID_EX,
    output bubble_EX, bubble_MEM, flush_all,
    output muldiv_start, muldiv_done, busy
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush scheduler: load-use detection, MULT/DIV
// sequencing FSM and flush > multi-cycle > load-use arbitration.
module pipeline_stall_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input logic            clk,
  input logic            rst_n,
  pipeline_stall_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD =
    CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD =
    CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic start;
  logic mdstall;
  logic lu;
  logic rs_hit;
  logic rt_hit;
  logic sel_flush;
  logic sel_md;
  logic sel_lu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (hz.flush_MEM) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hz.muldiv_EX) begin
            state_nxt = BUSY;
            cnt_nxt   = hz.is_div_EX ? DIV_LOAD
                                     : MULT_LOAD;
          end
        end
        BUSY: begin
          if (cnt > ONE) begin
            cnt_nxt = cnt - ONE;
          end else begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end
        end
        DONE: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Store data in rt is forwarded in MEM, so it never hazards here.
  assign rs_hit = hz.use_rs_ID
                & (hz.rs_addr_ID == hz.target_EX);
  assign rt_hit = hz.use_rt_ID & ~hz.store_ID
                & (hz.rt_addr_ID == hz.target_EX);
  assign lu = hz.MemRead_EX
            & (hz.target_EX != ZERO_REG)
            & (rs_hit | rt_hit);

  assign start = rst_n & ~hz.flush_MEM
               & (state == IDLE) & hz.muldiv_EX;
  assign mdstall = start | (rst_n & (state == BUSY));

  assign sel_flush = rst_n & hz.flush_MEM;
  assign sel_md    = ~sel_flush & mdstall;
  assign sel_lu    = rst_n & ~sel_flush & ~mdstall & lu;

  always_comb begin
    hz.stall_PC     = 1'b0;
    hz.stall_IF_ID  = 1'b0;
    hz.stall_ID_EX  = 1'b0;
    hz.bubble_EX    = 1'b0;
    hz.bubble_MEM   = 1'b0;
    hz.flush_all    = 1'b0;
    hz.muldiv_start = start;
    hz.muldiv_done  = rst_n & ~hz.flush_MEM
                    & (state == DONE);
    hz.busy         = rst_n & (state == BUSY);
    unique case (1'b1)
      sel_flush: begin
        hz.flush_all = 1'b1;
      end
      sel_md: begin
        hz.stall_PC    = 1'b1;
        hz.stall_IF_ID = 1'b1;
        hz.stall_ID_EX = 1'b1;
        hz.bubble_MEM  = 1'b1;
      end
      sel_lu: begin
        hz.stall_PC    = 1'b1;
        hz.stall_IF_ID = 1'b1;
        hz.bubble_EX   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: per-cycle model compare plus
// directed vectors with literal expectations.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.REG_ADDR_W(5)) bus ();

  pipeline_stall_ctrl #(
    .REG_ADDR_W (5),
    .MULT_CYCLES(4),
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model: an accepted op is k cycles old; stall while k<N, done at k==N.
  bit md_on = 1'b0;
  int md_k  = 0;
  int md_n  = 0;

  int cyc = 0;
  int last_done = -1;
  int n_stall = 0;
  int n_busy  = 0;
  int n_done  = 0;

  int s0, d0, st0, b0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // {stall_PC,stall_IF_ID,stall_ID_EX,bubble_EX,
  //  bubble_MEM,flush_all,muldiv_start,muldiv_done,busy}
  function automatic logic [8:0] outs();
    return {bus.stall_PC, bus.stall_IF_ID,
            bus.stall_ID_EX, bus.bubble_EX,
            bus.bubble_MEM, bus.flush_all,
            bus.muldiv_start, bus.muldiv_done,
            bus.busy};
  endfunction

  always @(negedge clk) begin
    logic lu, s, b, d, ms;
    logic [8:0] e;
    lu = bus.MemRead_EX && bus.target_EX != 5'd0 &&
         ((bus.use_rs_ID &&
           bus.rs_addr_ID == bus.target_EX) ||
          (bus.use_rt_ID && !bus.store_ID &&
           bus.rt_addr_ID == bus.target_EX));
    b  = md_on && md_k < md_n;
    d  = md_on && md_k == md_n;
    s  = !md_on && bus.muldiv_EX && !bus.flush_MEM;
    ms = s || b;
    e  = '0;
    if (rst_n) begin
      if (bus.flush_MEM) begin
        e[3] = 1'b1;
        e[0] = b;
      end else if (ms) begin
        e[8] = 1'b1; e[7] = 1'b1;
        e[6] = 1'b1; e[4] = 1'b1;
        e[2] = s;    e[0] = b;
      end else begin
        if (lu) begin
          e[8] = 1'b1; e[7] = 1'b1; e[5] = 1'b1;
        end
        e[1] = d;
      end
    end
    chk("cycle_outputs", 32'(outs()), 32'(e));
    if (bus.stall_ID_EX) n_stall++;
    if (bus.busy) n_busy++;
    if (bus.muldiv_done) begin
      n_done++;
      last_done = cyc;
    end
    cyc++;
    if (!rst_n || bus.flush_MEM) begin
      md_on = 1'b0;
    end else if (s) begin
      md_on = 1'b1;
      md_k  = 1;
      md_n  = bus.is_div_EX ? 32 : 4;
    end else if (md_on) begin
      if (md_k == md_n) md_on = 1'b0;
      else md_k++;
    end
  end

  task automatic clr();
    bus.rs_addr_ID = '0;
    bus.rt_addr_ID = '0;
    bus.use_rs_ID  = 1'b0;
    bus.use_rt_ID  = 1'b0;
    bus.store_ID   = 1'b0;
    bus.target_EX  = '0;
    bus.MemRead_EX = 1'b0;
    bus.muldiv_EX  = 1'b0;
    bus.is_div_EX  = 1'b0;
    bus.flush_MEM  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(string nm, logic [8:0] exp);
    #1;
    chk(nm, 32'(outs()), 32'(exp));
  endtask

  task automatic snap();
    s0  = cyc;
    d0  = n_done;
    st0 = n_stall;
    b0  = n_busy;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    bus.muldiv_EX = 1'b1;
    tick();
    look("reset_cycle1", 9'b000_000_000);
    tick();
    look("reset_cycle2", 9'b000_000_000);
    tick();
    rst_n = 1'b1;
    snap();
    look("release_start", 9'b111_010_100);
    repeat (4) tick();
    look("mult_done", 9'b000_000_010);
    tick();
    clr();
    look("mult_idle", 9'b000_000_000);
    chk("mult_stall_cycles", n_stall - st0, 4);
    chk("mult_busy_cycles", n_busy - b0, 3);
    chk("mult_done_count", n_done - d0, 1);
    chk("mult_done_offset", last_done - s0, 4);

    bus.MemRead_EX = 1'b1;
    bus.target_EX  = 5'd8;
    bus.rs_addr_ID = 5'd8;
    bus.use_rs_ID  = 1'b1;
    look("lu_rs", 9'b110_100_000);
    tick();
    bus.target_EX = 5'd0;
    bus.rs_addr_ID = 5'd0;
    look("lu_zero_reg", 9'b000_000_000);
    tick();
    bus.target_EX  = 5'd9;
    bus.rs_addr_ID = 5'd3;
    bus.rt_addr_ID = 5'd9;
    bus.use_rt_ID  = 1'b1;
    bus.store_ID   = 1'b1;
    look("lu_store_rt", 9'b000_000_000);
    tick();
    bus.store_ID = 1'b0;
    look("lu_rt", 9'b110_100_000);
    tick();
    clr();

    bus.muldiv_EX = 1'b1;
    bus.is_div_EX = 1'b1;
    snap();
    look("div_start", 9'b111_010_100);
    repeat (32) tick();
    look("div_done", 9'b000_000_010);
    tick();
    clr();
    look("div_idle", 9'b000_000_000);
    chk("div_stall_cycles", n_stall - st0, 32);
    chk("div_busy_cycles", n_busy - b0, 31);
    chk("div_done_count", n_done - d0, 1);
    chk("div_done_offset", last_done - s0, 32);

    tick();
    bus.muldiv_EX = 1'b1;
    bus.is_div_EX = 1'b1;
    snap();
    repeat (10) tick();
    bus.flush_MEM = 1'b1;
    look("flush_mid_div", 9'b000_001_001);
    tick();
    clr();
    look("busy_after_flush", 9'b000_000_000);
    repeat (40) tick();
    chk("flush_no_done", n_done - d0, 0);

    bus.MemRead_EX = 1'b1;
    bus.target_EX  = 5'd8;
    bus.rs_addr_ID = 5'd8;
    bus.use_rs_ID  = 1'b1;
    bus.muldiv_EX  = 1'b1;
    look("lu_vs_start", 9'b111_010_100);
    repeat (4) tick();
    look("lu_after_done", 9'b110_100_010);
    tick();
    clr();

    bus.muldiv_EX = 1'b1;
    bus.flush_MEM = 1'b1;
    look("flush_vs_start", 9'b000_001_000);
    tick();
    clr();
    look("idle_after_flush_start", 9'b000_000_000);

    tick();
    bus.muldiv_EX = 1'b1;
    snap();
    tick();
    tick();
    rst_n = 1'b0;
    look("reset_mid_busy", 9'b000_000_000);
    tick();
    rst_n = 1'b1;
    clr();
    look("after_reset_idle", 9'b000_000_000);
    repeat (6) tick();
    chk("reset_abort_no_done", n_done - d0, 0);

    tick();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
